// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl
//   Frame sequencer for the viterbi_simple_v2 decoder. Collects one frame of
//   2-bit code symbols into the decoder symbol memory, pulses the decoder
//   start, waits for done under a watchdog, then streams the decoded bits out
//   one per valid/ready handshake.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_flush                         synchronous abort to IDLE
//   i_in_valid/o_in_ready           symbol stream handshake
//   i_in_sym/i_in_last              symbol {G0,G1} and end-of-frame marker
//   o_sym_we/o_sym_addr/o_sym_data  decoder symbol-memory write port
//   o_dec_start/o_dec_frame_len     decoder start pulse and frame length
//   i_dec_done/i_dec_out_len        decoder completion and decoded bit count
//   o_bit_addr/i_bit_data           decoded-bit read port (1-cycle latency)
//   o_out_valid/i_out_ready         decoded bit stream handshake
//   o_out_bit/o_out_last            decoded bit and final-bit marker
//   o_busy                          controller not idle
//   o_err_overflow/o_err_timeout    sticky error flags, cleared at next start
//   o_frame_cnt                     number of fully drained frames
module viterbi_frame_ctrl #(
  parameter int MAX_LEN = 255,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [1:0]  i_in_sym,
  input  logic        i_in_last,
  output logic        o_sym_we,
  output logic [7:0]  o_sym_addr,
  output logic [1:0]  o_sym_data,
  output logic        o_dec_start,
  output logic [7:0]  o_dec_frame_len,
  input  logic        i_dec_done,
  input  logic [7:0]  i_dec_out_len,
  output logic [7:0]  o_bit_addr,
  input  logic        i_bit_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_out_bit,
  output logic        o_out_last,
  output logic        o_busy,
  output logic        o_err_overflow,
  output logic        o_err_timeout,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_RDREQ, S_OUTV
  } state_t;

  localparam logic [7:0]      LAST_IDX = 8'(MAX_LEN - 1);
  localparam logic [TO_W-1:0] WD_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] WD_ONE   = TO_W'(1);

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_wr_ptr;
  logic [7:0]      r_rd_ptr;
  logic [7:0]      r_olen;
  logic [7:0]      r_frame_len;
  logic [TO_W-1:0] r_wd;
  logic            r_drop;      // frame was truncated; swallow symbols until in_last
  logic            r_err_ovf;
  logic            r_err_to;
  logic            r_cap;       // out_bit has been captured for the current OUTV
  logic            r_out_bit;
  logic [15:0]     r_frame_cnt;

  logic            w_sym_we;
  logic            w_is_last;

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    w_sym_we     = 1'b0;
    o_dec_start  = 1'b0;
    o_out_valid  = 1'b0;
    w_is_last    = (r_rd_ptr == r_olen - 8'd1);
    // Flush suppresses every strobe in its cycle, so the whole case is skipped.
    if (i_flush) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_LOAD;
        S_LOAD: begin
          o_in_ready = 1'b1;
          w_sym_we   = i_in_valid && !r_drop;
          // A truncated frame stays here, dropping symbols, until in_last.
          if (i_in_valid && i_in_last) w_state_next = S_START;
        end
        S_START: begin
          o_dec_start  = 1'b1;
          w_state_next = S_WAIT;
        end
        S_WAIT: begin
          if (i_dec_done)
            w_state_next = (i_dec_out_len == 8'd0) ? S_IDLE : S_RDREQ;
          else if (r_wd == WD_LAST)
            w_state_next = S_IDLE;
        end
        S_RDREQ: w_state_next = S_OUTV;
        S_OUTV: begin
          o_out_valid = 1'b1;
          if (i_out_ready) w_state_next = w_is_last ? S_IDLE : S_RDREQ;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= 8'd0;
      r_rd_ptr    <= 8'd0;
      r_olen      <= 8'd0;
      r_frame_len <= 8'd0;
      r_wd        <= '0;
      r_drop      <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_to    <= 1'b0;
      r_cap       <= 1'b0;
      r_out_bit   <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state <= w_state_next;
      if (!i_flush) begin
        case (r_state)
          S_IDLE: begin
            r_wr_ptr <= 8'd0;
            r_drop   <= 1'b0;
          end
          S_LOAD: begin
            if (w_sym_we) begin
              r_wr_ptr <= r_wr_ptr + 8'd1;
              if (i_in_last || r_wr_ptr == LAST_IDX)
                r_frame_len <= r_wr_ptr + 8'd1;
              if (!i_in_last && r_wr_ptr == LAST_IDX) begin
                r_drop    <= 1'b1;
                r_err_ovf <= 1'b1;
              end
            end
          end
          S_START: begin
            // Keep an overflow raised by the frame being started.
            r_err_ovf <= r_drop;
            r_err_to  <= 1'b0;
            r_wd      <= '0;
          end
          S_WAIT: begin
            r_wd <= r_wd + WD_ONE;
            if (i_dec_done) begin
              r_olen   <= i_dec_out_len;
              r_rd_ptr <= 8'd0;
              if (i_dec_out_len == 8'd0) r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (r_wd == WD_LAST) begin
              r_err_to <= 1'b1;
            end
          end
          S_RDREQ: r_cap <= 1'b0;
          S_OUTV: begin
            // Read data arrives in the first OUTV cycle; freeze it for stalls.
            if (!r_cap) begin
              r_out_bit <= i_bit_data;
              r_cap     <= 1'b1;
            end
            if (i_out_ready) begin
              if (w_is_last) r_frame_cnt <= r_frame_cnt + 16'd1;
              else           r_rd_ptr    <= r_rd_ptr + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_sym_we        = w_sym_we;
  assign o_sym_addr      = r_wr_ptr;
  assign o_sym_data      = w_sym_we ? i_in_sym : 2'b00;
  assign o_dec_frame_len = r_frame_len;
  assign o_bit_addr      = r_rd_ptr;
  assign o_out_bit       = o_out_valid && (r_cap ? r_out_bit : i_bit_data);
  assign o_out_last      = o_out_valid && w_is_last;
  assign o_busy          = (r_state != S_IDLE);
  assign o_err_overflow  = r_err_ovf;
  assign o_err_timeout   = r_err_to;
  assign o_frame_cnt     = r_frame_cnt;

endmodule
